rggen_bus_exporter_multi: RTL and testbench

- Parametrised successor of the single-window bus exporter: one instance serves CHANNELS external register windows behind one local register-block bus.
- Latches the host command once, forwards it with the window-relative address to the selected channel, and waits for that channel's ready.
- Adds a watchdog timeout that aborts a hung access and returns an error status.
- Sits between the register-block command/response path and the external slaves; its ready, status and read data feed the response mux.

---
 rtl/rggen_rtl_pkg.sv | 22 ++
 rtl/rggen_onehot_to_index.sv | 25 ++
 rtl/rggen_bus_exporter_multi.sv | 149 ++++++++++++++
 tb/tb_rggen_bus_exporter_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen bus exporter family.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY        = 2'b00,
    RGGEN_SLAVE_ERROR = 2'b10,
    RGGEN_TIMEOUT     = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } rggen_exporter_state;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned rggen_index_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rggen_onehot_to_index.sv
// Lowest-set-bit priority encoder used to pick the active exporter channel.
module rggen_onehot_to_index
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned INDEX_WIDTH = rggen_index_width(WIDTH)
) (
  input  logic [WIDTH-1:0]       select_i,
  output logic [INDEX_WIDTH-1:0] index_c,
  output logic                   found_c
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index_c = '0;
    found_c = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (select_i[i]) begin
        index_c = INDEX_WIDTH'(i);
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rggen_bus_exporter_multi.sv
// Multi-window bus exporter: forwards one latched host command to the selected
// external channel and returns its response, with an optional watchdog abort.
module rggen_bus_exporter_multi
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned LOCAL_ADDRESS_WIDTH    = 8,
  parameter int unsigned EXTERNAL_ADDRESS_WIDTH = 7,
  parameter int unsigned CHANNELS               = 2,
  parameter logic [CHANNELS*LOCAL_ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
  parameter int unsigned TIMEOUT_CYCLES         = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_valid,
  input  logic [CHANNELS-1:0]                  i_select,
  input  logic                                 i_write,
  input  logic                                 i_read,
  input  logic [LOCAL_ADDRESS_WIDTH-1:0]       i_address,
  input  logic [DATA_WIDTH/8-1:0]              i_strobe,
  input  logic [DATA_WIDTH-1:0]                i_write_data,
  output logic                                 o_ready,
  output logic [DATA_WIDTH-1:0]                o_read_data,
  output logic [1:0]                           o_status,
  output logic [CHANNELS-1:0]                  o_valid,
  output logic                                 o_write,
  output logic                                 o_read,
  output logic [EXTERNAL_ADDRESS_WIDTH-1:0]    o_address,
  output logic [DATA_WIDTH/8-1:0]              o_strobe,
  output logic [DATA_WIDTH-1:0]                o_write_data,
  input  logic [CHANNELS-1:0]                  i_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       i_read_data,
  input  logic [CHANNELS*2-1:0]                i_status
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W   = rggen_index_width(CHANNELS);
  localparam int unsigned CNT_W   = rggen_index_width(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  rggen_exporter_state               state_q;
  logic [IDX_W-1:0]                  ch_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [CHANNELS-1:0]               valid_q;
  logic                              write_q;
  logic                              read_q;
  logic [EXTERNAL_ADDRESS_WIDTH-1:0] addr_q;
  logic [STRB_W-1:0]                 strobe_q;
  logic [DATA_WIDTH-1:0]             wdata_q;
  logic                              ready_q;
  logic [DATA_WIDTH-1:0]             rdata_q;
  logic [1:0]                        status_q;

  logic [IDX_W-1:0]               sel_idx;
  logic                           sel_found;
  logic                           accept;
  logic [LOCAL_ADDRESS_WIDTH-1:0] rel_addr;
  logic                           sel_ready;
  logic [DATA_WIDTH-1:0]          sel_rdata;
  logic [1:0]                     sel_status;
  logic                           timeout_hit;

  rggen_onehot_to_index #(
    .WIDTH       (CHANNELS),
    .INDEX_WIDTH (IDX_W)
  ) u_select (
    .select_i (i_select),
    .index_c  (sel_idx),
    .found_c  (sel_found)
  );

  assign accept      = i_valid && sel_found && (i_write || i_read);
  assign rel_addr    = i_address - START_ADDRESS[sel_idx*LOCAL_ADDRESS_WIDTH +: LOCAL_ADDRESS_WIDTH];
  assign sel_ready   = i_ready[ch_q];
  assign sel_rdata   = i_read_data[ch_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_status  = i_status[ch_q*2 +: 2];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      status_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ch_q     <= sel_idx;
            write_q  <= i_write;
            read_q   <= i_read;
            addr_q   <= EXTERNAL_ADDRESS_WIDTH'(rel_addr);
            strobe_q <= i_strobe;
            wdata_q  <= i_write_data;
            valid_q  <= CHANNELS'(1) << sel_idx;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A ready arriving on the watchdog's last cycle still delivers real data.
          if (sel_ready) begin
            valid_q  <= '0;
            ready_q  <= 1'b1;
            rdata_q  <= write_q ? '0 : sel_rdata;
            status_q <= sel_status;
            state_q  <= RESP;
          end else if (timeout_hit) begin
            valid_q  <= '0;
            ready_q  <= 1'b1;
            rdata_q  <= '0;
            status_q <= RGGEN_TIMEOUT;
            state_q  <= RESP;
          end
        end
        RESP: begin
          ready_q  <= 1'b0;
          rdata_q  <= '0;
          status_q <= '0;
          write_q  <= 1'b0;
          read_q   <= 1'b0;
          cnt_q    <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_read_data  = rdata_q;
  assign o_status     = status_q;
  assign o_valid      = valid_q;
  assign o_write      = write_q;
  assign o_read       = read_q;
  assign o_address    = addr_q;
  assign o_strobe     = strobe_q;
  assign o_write_data = wdata_q;

endmodule

// File: tb/tb_rggen_bus_exporter_multi.sv
// Self-checking bench for rggen_bus_exporter_multi (2 channels, 8-cycle watchdog).
module tb_rggen_bus_exporter_multi;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [1:0]  i_select;
  logic        i_write;
  logic        i_read;
  logic [7:0]  i_address;
  logic [3:0]  i_strobe;
  logic [31:0] i_write_data;
  logic        o_ready;
  logic [31:0] o_read_data;
  logic [1:0]  o_status;
  logic [1:0]  o_valid;
  logic        o_write;
  logic        o_read;
  logic [6:0]  o_address;
  logic [3:0]  o_strobe;
  logic [31:0] o_write_data;
  logic [1:0]  i_ready;
  logic [63:0] i_read_data;
  logic [3:0]  i_status;

  int checks = 0;
  int errors = 0;

  logic [7:0] bases [2] = '{8'h80, 8'hC0};

  rggen_bus_exporter_multi #(
    .DATA_WIDTH             (32),
    .LOCAL_ADDRESS_WIDTH    (8),
    .EXTERNAL_ADDRESS_WIDTH (7),
    .CHANNELS               (2),
    .START_ADDRESS          (16'hC080),
    .TIMEOUT_CYCLES         (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_select     (i_select),
    .i_write      (i_write),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_strobe     (i_strobe),
    .i_write_data (i_write_data),
    .o_ready      (o_ready),
    .o_read_data  (o_read_data),
    .o_status     (o_status),
    .o_valid      (o_valid),
    .o_write      (o_write),
    .o_read       (o_read),
    .o_address    (o_address),
    .o_strobe     (o_strobe),
    .o_write_data (o_write_data),
    .i_ready      (i_ready),
    .i_read_data  (i_read_data),
    .i_status     (i_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic [1:0]  rstat;
    logic        other_hi;
    logic [1:0]  exp_valid;
    logic [6:0]  exp_addr;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: lowest set bit picks the window; address is offset from its base.
  task automatic model(input logic [1:0] sel, input logic wr, input logic [7:0] addr,
                       input int delay, input logic [31:0] rdata, input logic [1:0] rstat,
                       output logic [1:0] ev, output logic [6:0] ea,
                       output logic [1:0] es, output logic [31:0] ed);
    int ch;
    logic [7:0] diff;
    ch = sel[0] ? 0 : 1;
    ev = 2'b00;
    ev[ch] = 1'b1;
    diff = addr - bases[ch];
    ea = diff[6:0];
    if (delay < TO) begin
      es = rstat;
      ed = wr ? 32'h0 : rdata;
    end else begin
      es = 2'b11;
      ed = 32'h0;
    end
  endtask

  // Called one time unit after an edge while the DUT is idle.
  task automatic run_txn(input string tag, input vec_t v);
    int n_busy;
    int chn;
    n_busy = (v.delay < TO) ? v.delay + 1 : TO;
    chn = v.exp_valid[0] ? 0 : 1;
    i_valid = 1'b1; i_select = v.sel; i_write = v.wr; i_read = !v.wr;
    i_address = v.addr; i_strobe = v.strb; i_write_data = v.wdata; i_ready = 2'b00;
    step();
    for (int k = 0; k < n_busy; k++) begin
      check($sformatf("%s_busy%0d", tag, k),
            {16'h0, o_valid, o_write, o_read, o_address, o_strobe, o_write_data, o_ready},
            {16'h0, v.exp_valid, v.wr, !v.wr, v.exp_addr, v.strb, v.wdata, 1'b0});
      i_valid = 1'($urandom); i_select = 2'($urandom); i_write = 1'($urandom);
      i_read = 1'($urandom); i_address = 8'($urandom); i_strobe = 4'($urandom);
      i_write_data = $urandom;
      i_ready = v.other_hi ? 2'b11 : 2'($urandom);
      i_ready[chn] = (k == v.delay);
      i_read_data = {$urandom, $urandom};
      i_read_data[chn*32 +: 32] = v.rdata;
      i_status = 4'($urandom);
      i_status[chn*2 +: 2] = v.rstat;
      step();
    end
    i_valid = 1'b0; i_ready = 2'b00;
    check($sformatf("%s_resp", tag), {27'h0, o_ready, o_valid, o_status, o_read_data},
          {27'h0, 1'b1, 2'b00, v.exp_status, v.exp_rdata});
    step();
    check($sformatf("%s_after", tag), {27'h0, o_ready, o_valid, o_status, o_read_data}, 64'h0);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{2'b10, 1'b1, 8'hC4, 4'hF, 32'hDEADBEEF, 0,  32'hAAAA5555, 2'b00, 1'b0, 2'b10, 7'h04, 2'b00, 32'h0};
    vecs[1] = '{2'b01, 1'b0, 8'h88, 4'h3, 32'h0,        4,  32'h12345678, 2'b10, 1'b0, 2'b01, 7'h08, 2'b10, 32'h12345678};
    vecs[2] = '{2'b01, 1'b0, 8'h80, 4'hF, 32'h0,        20, 32'hFFFFFFFF, 2'b00, 1'b0, 2'b01, 7'h00, 2'b11, 32'h0};
    vecs[3] = '{2'b10, 1'b0, 8'hFF, 4'hF, 32'h0,        1,  32'hCAFEF00D, 2'b00, 1'b0, 2'b10, 7'h3F, 2'b00, 32'hCAFEF00D};
    vecs[4] = '{2'b10, 1'b0, 8'hC8, 4'hF, 32'h0,        7,  32'h0BADF00D, 2'b10, 1'b0, 2'b10, 7'h08, 2'b10, 32'h0BADF00D};
    vecs[5] = '{2'b11, 1'b1, 8'h84, 4'h5, 32'h11223344, 2,  32'h55555555, 2'b00, 1'b0, 2'b01, 7'h04, 2'b00, 32'h0};
    vecs[6] = '{2'b10, 1'b0, 8'h10, 4'hF, 32'h0,        3,  32'h87654321, 2'b00, 1'b0, 2'b10, 7'h50, 2'b00, 32'h87654321};
    vecs[7] = '{2'b11, 1'b0, 8'h8C, 4'hF, 32'h0,        20, 32'h13579BDF, 2'b10, 1'b1, 2'b01, 7'h0C, 2'b11, 32'h0};

    rst_n = 1'b0; i_valid = 1'b0; i_select = '0; i_write = 1'b0; i_read = 1'b0;
    i_address = '0; i_strobe = '0; i_write_data = '0; i_ready = '0;
    i_read_data = '0; i_status = '0;
    step();
    step();
    check("reset_req", {16'h0, o_valid, o_write, o_read, o_address, o_strobe, o_write_data, o_ready}, 64'h0);
    check("reset_rsp", {29'h0, o_status, o_read_data}, 64'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Commands without a select or without read/write must not start an access.
    i_valid = 1'b1; i_select = 2'b00; i_read = 1'b1; i_write = 1'b0;
    step();
    step();
    check("no_select", {62'h0, o_valid}, 64'h0);
    i_select = 2'b01; i_read = 1'b0;
    step();
    step();
    check("no_rw", {61'h0, o_ready, o_valid}, 64'h0);
    i_valid = 1'b0;
    step();

    // Reset asserted on the third BUSY cycle.
    i_valid = 1'b1; i_select = 2'b01; i_read = 1'b1; i_write = 1'b0; i_address = 8'h90;
    step();
    i_valid = 1'b0;
    check("rst_mid_busy", {62'h0, o_valid}, 64'h1);
    step();
    step();
    rst_n = 1'b0;
    step();
    check("rst_mid_drop", {27'h0, o_ready, o_valid, o_status, o_read_data}, 64'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rst_mid_quiet%0d", k), {61'h0, o_ready, o_valid}, 64'h0);
    end
    run_txn("post_rst", vecs[3]);

    for (int i = 0; i < 40; i++) begin
      rv.sel = 2'($urandom_range(1, 3));
      rv.wr = 1'($urandom);
      rv.addr = 8'($urandom);
      rv.strb = 4'($urandom);
      rv.wdata = $urandom;
      rv.delay = $urandom_range(0, 10);
      rv.rdata = $urandom;
      rv.rstat = 2'($urandom);
      rv.other_hi = 1'($urandom);
      model(rv.sel, rv.wr, rv.addr, rv.delay, rv.rdata, rv.rstat,
            rv.exp_valid, rv.exp_addr, rv.exp_status, rv.exp_rdata);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
